// File: rtl/io_pkg.sv
// Shared constants for the port-mapped I/O responder: port address map,
// status word layout and the port address type.
package io_pkg;

   // Width of the processor port address field (IR[11:7]).
   localparam int IO_ADDR_W = 5;
   typedef logic [IO_ADDR_W-1:0] io_addr_t;

   // Port address map.
   localparam int IO_IN_BASE     = 0;
   localparam int IO_OUT_BASE    = 16;
   localparam int IO_STATUS_ADDR = 31;

   // Status word layout.
   localparam int STAT_IN_LSB  = 0;
   localparam int STAT_OUT_LSB = 8;
   localparam int STAT_OVF_BIT = 15;

   // True when the processor address selects the given port number.
   function automatic logic port_hit(input io_addr_t addr, input int port);
      return addr == io_addr_t'(port);
   endfunction

endpackage

// File: rtl/io_in_chan.sv
// One input channel: a single holding register plus full flag. A producer
// fills it through a valid/ready handshake; the processor empties it with
// an IN instruction addressed to this channel.
module io_in_chan #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          consume,
   output logic [DW-1:0] hold_data,
   output logic          full
);

   logic [DW-1:0] ih_q, ih_d;
   logic          full_q, full_d;
   logic          capture;

   // Ready is withheld during reset so no handshake completes on a reset edge.
   assign in_ready  = ~full_q & ~reset;
   assign capture   = in_valid & in_ready;
   assign hold_data = ih_q;
   assign full      = full_q;

   // Next state: capture fills the channel, a processor read of a full channel empties it.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      ih_d   = ih_q;
      full_d = full_q;
      if (capture) begin
         ih_d   = in_data;
         full_d = 1'b1;
      end else if (consume) begin
         // Consuming an empty channel is harmless: the flag is already low.
         full_d = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: the data register is reset too, because reads of an idle channel must return 0, not X.
      if (reset) begin
         ih_q   <= '0;
         full_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values.
         ih_q   <= ih_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Port-mapped I/O responder for the 16-bit datapath. Decodes the 5-bit port
// address for IN/OUT, returns input data combinationally, and holds OUT data
// in per-channel registers with valid/ready toward external consumers.
// Optional feature macro: IO_STATUS_EN (status port at 31 and sticky ovf bit).
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 4,
   parameter int DW    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           dirport,
   input  logic                 io_rd,
   input  logic                 io_wr,
   input  logic [DW-1:0]        wr_data,
   output logic [DW-1:0]        rd_data,
   input  logic [N_IN*DW-1:0]   in_data,
   input  logic [N_IN-1:0]      in_valid,
   output logic [N_IN-1:0]      in_ready,
   output logic [N_OUT*DW-1:0]  out_data,
   output logic [N_OUT-1:0]     out_valid,
   input  logic [N_OUT-1:0]     out_ready
);

   // ------------------------------------------------------------------
   // Input channels
   // ------------------------------------------------------------------
   logic [N_IN-1:0] in_full;
   logic [N_IN-1:0] consume;
   logic [DW-1:0]   ih [N_IN];

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      // A read only consumes when it is not paired with a write.
      assign consume[gi] = io_rd & ~io_wr & port_hit(dirport, IO_IN_BASE + gi);

      io_in_chan #(.DW(DW)) u_chan (
         .clk       (clk),
         .reset     (reset),
         .in_data   (in_data[gi*DW +: DW]),
         .in_valid  (in_valid[gi]),
         .in_ready  (in_ready[gi]),
         .consume   (consume[gi]),
         .hold_data (ih[gi]),
         .full      (in_full[gi])
      );
   end

   // ------------------------------------------------------------------
   // Output channels
   // ------------------------------------------------------------------
   logic [N_OUT-1:0] out_busy_q, out_busy_d;
   logic [DW-1:0]    oh_q [N_OUT];
   logic [DW-1:0]    oh_d [N_OUT];
   logic [N_OUT-1:0] xfer;
   logic [N_OUT-1:0] wr_hit;
   logic [N_OUT-1:0] wr_accept;

   // Handshake and write decode per output channel.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         xfer[j]      = out_busy_q[j] & out_ready[j];
         wr_hit[j]    = io_wr & port_hit(dirport, IO_OUT_BASE + j);
         // A busy channel still accepts if its word leaves on this same edge.
         wr_accept[j] = wr_hit[j] & (~out_busy_q[j] | xfer[j]);
      end
   end

   // Next state: an accepted write reloads the channel, otherwise a transfer empties it.
   always_comb begin
      out_busy_d = out_busy_q;
      oh_d       = oh_q;
      for (int j = 0; j < N_OUT; j++) begin
         if (wr_accept[j]) begin
            oh_d[j]       = wr_data;
            out_busy_d[j] = 1'b1;
         end else if (xfer[j]) begin
            out_busy_d[j] = 1'b0;
         end
      end
   end

   // Output holding registers and busy flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_busy_q <= '0;
         for (int j = 0; j < N_OUT; j++) oh_q[j] <= '0;
      end else begin
         out_busy_q <= out_busy_d;
         oh_q       <= oh_d;
      end
   end

   for (genvar gj = 0; gj < N_OUT; gj++) begin : g_out
      assign out_data[gj*DW +: DW] = oh_q[gj];
   end
   assign out_valid = out_busy_q;

   // ------------------------------------------------------------------
   // Status port and overflow flag
   // ------------------------------------------------------------------
   logic [DW-1:0] status_word;

`ifdef IO_STATUS_EN
   logic ovf_q, ovf_d;
   logic status_rd;
   logic wr_drop;

   assign wr_drop   = |(wr_hit & ~wr_accept);
   assign status_rd = io_rd & ~io_wr & port_hit(dirport, IO_STATUS_ADDR);

   // Sticky overflow: a status read clears it, but a drop on the same edge wins.
   always_comb begin
      ovf_d = ovf_q;
      if (status_rd) ovf_d = 1'b0;
      if (wr_drop)   ovf_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   // Status word: in_full low byte, out_busy high byte with its top bit replaced by ovf.
   always_comb begin
      status_word                         = '0;
      status_word[STAT_IN_LSB +: N_IN]    = in_full;
      status_word[STAT_OUT_LSB +: N_OUT]  = out_busy_q;
      status_word[STAT_OVF_BIT]           = ovf_q;
   end
`else
   assign status_word = '0;
`endif

   // ------------------------------------------------------------------
   // Read mux: zero-latency, unmapped addresses return 0.
   // ------------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N_IN; i++)
         if (port_hit(dirport, IO_IN_BASE + i)) rd_data = ih[i];
      for (int j = 0; j < N_OUT; j++)
         if (port_hit(dirport, IO_OUT_BASE + j)) rd_data = oh_q[j];
      if (port_hit(dirport, IO_STATUS_ADDR)) rd_data = status_word;
   end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: a directed vector table walking the main scenarios,
// then randomized traffic compared every cycle against a behavioural model.
// Honours IO_STATUS_EN so either build can be checked.
module tb_io_port_ctrl;

   localparam int N_IN  = 4;
   localparam int N_OUT = 4;
   localparam int DW    = 16;
`ifdef IO_STATUS_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic                clk;
   logic                reset;
   logic [4:0]          dirport;
   logic                io_rd;
   logic                io_wr;
   logic [DW-1:0]       wr_data;
   logic [DW-1:0]       rd_data;
   logic [N_IN*DW-1:0]  in_data;
   logic [N_IN-1:0]     in_valid;
   logic [N_IN-1:0]     in_ready;
   logic [N_OUT*DW-1:0] out_data;
   logic [N_OUT-1:0]    out_valid;
   logic [N_OUT-1:0]    out_ready;

   io_port_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .dirport   (dirport),
      .io_rd     (io_rd),
      .io_wr     (io_wr),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_ih   [N_IN];
   bit            m_full [N_IN];
   logic [DW-1:0] m_oh   [N_OUT];
   bit            m_busy [N_OUT];
   bit            m_ovf;

   function automatic logic [DW-1:0] model_rd(input logic [4:0] a);
      int ai = int'(a);
      logic [DW-1:0] s = '0;
      if (ai < N_IN) return m_ih[ai];
      if (ai >= 16 && ai < 16 + N_OUT) return m_oh[ai - 16];
      if (ai == 31 && STAT_EN) begin
         for (int i = 0; i < N_IN; i++) s[i] = m_full[i];
         for (int j = 0; j < N_OUT; j++) s[8 + j] = m_busy[j];
         s[15] = m_ovf;
         return s;
      end
      return '0;
   endfunction

   // Apply one clock edge's worth of rules to the model, using the driven inputs.
   task automatic model_update();
      int  a = int'(dirport);
      bit  dropped = 1'b0;
      if (reset) begin
         for (int i = 0; i < N_IN; i++) begin m_ih[i] = '0; m_full[i] = 1'b0; end
         for (int j = 0; j < N_OUT; j++) begin m_oh[j] = '0; m_busy[j] = 1'b0; end
         m_ovf = 1'b0;
         return;
      end
      for (int i = 0; i < N_IN; i++) begin
         if (in_valid[i] && !m_full[i]) begin
            m_ih[i]   = in_data[i*DW +: DW];
            m_full[i] = 1'b1;
         end else if (io_rd && !io_wr && a == i) begin
            m_full[i] = 1'b0;
         end
      end
      for (int j = 0; j < N_OUT; j++) begin
         bit sent = m_busy[j] && out_ready[j];
         if (io_wr && a == 16 + j) begin
            if (!m_busy[j] || sent) begin
               m_oh[j]   = wr_data;
               m_busy[j] = 1'b1;
               continue;
            end
            dropped = 1'b1;
         end
         if (sent) m_busy[j] = 1'b0;
      end
      if (STAT_EN) begin
         if (io_rd && !io_wr && a == 31) m_ovf = 1'b0;
         if (dropped) m_ovf = 1'b1;
      end
   endtask

   // Drive inputs, then compare every output against the model at the falling edge.
   task automatic step_pre(input bit rst, input logic [4:0] dp, input bit rd, input bit wr,
                           input logic [DW-1:0] wd, input logic [N_IN*DW-1:0] idv,
                           input logic [N_IN-1:0] iv, input logic [N_OUT-1:0] ordy,
                           input string tag);
      logic [N_IN-1:0] exp_ir;
      reset = rst; dirport = dp; io_rd = rd; io_wr = wr; wr_data = wd;
      in_data = idv; in_valid = iv; out_ready = ordy;
      @(negedge clk);
      for (int i = 0; i < N_IN; i++) exp_ir[i] = !rst && !m_full[i];
      check({tag, " model rd_data"}, 32'(rd_data), 32'(model_rd(dp)));
      check({tag, " model in_ready"}, 32'(in_ready), 32'(exp_ir));
      for (int j = 0; j < N_OUT; j++) begin
         check($sformatf("%s model out_valid[%0d]", tag, j), 32'(out_valid[j]), 32'(m_busy[j]));
         check($sformatf("%s model out_data[%0d]", tag, j), 32'(out_data[j*DW +: DW]), 32'(m_oh[j]));
      end
   endtask

   task automatic step_post();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit              rst;
      logic [4:0]      dp;
      bit              rd;
      bit              wr;
      logic [DW-1:0]   wd;
      logic [DW-1:0]   iw;
      logic [N_IN-1:0] iv;
      logic [N_OUT-1:0] ordy;
      logic [DW-1:0]   exp_rd;
      logic [N_IN-1:0] exp_ir;
      logic [N_OUT-1:0] exp_ov;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [DW-1:0] st_8100, st_0100, st_0900;
      st_8100 = STAT_EN ? 16'h8100 : 16'h0000;
      st_0100 = STAT_EN ? 16'h0100 : 16'h0000;
      st_0900 = STAT_EN ? 16'h0900 : 16'h0000;

      // rst dp rd wr wdata iword ivalid oready | exp_rd exp_in_ready exp_out_valid
      vecs.push_back('{1, 5'd0,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000}); // 0 in reset
      vecs.push_back('{0, 5'd0,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 1 idle
      vecs.push_back('{0, 5'd16, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 2
      vecs.push_back('{0, 5'd31, 0, 0, 16'h0000, 16'hBEEF, 4'b0100, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 3 capture ch2
      vecs.push_back('{0, 5'd2,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'hBEEF, 4'b1011, 4'b0000}); // 4
      vecs.push_back('{0, 5'd2,  1, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'hBEEF, 4'b1011, 4'b0000}); // 5 consume
      vecs.push_back('{0, 5'd2,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'hBEEF, 4'b1111, 4'b0000}); // 6 stale
      vecs.push_back('{0, 5'd17, 0, 1, 16'h1234, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 7 OUT ch1
      vecs.push_back('{0, 5'd17, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h1234, 4'b1111, 4'b0010}); // 8
      vecs.push_back('{0, 5'd17, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h1234, 4'b1111, 4'b0010}); // 9 transfer
      vecs.push_back('{0, 5'd17, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h1234, 4'b1111, 4'b0000}); // 10
      vecs.push_back('{0, 5'd16, 0, 1, 16'h1111, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 11 OUT ch0
      vecs.push_back('{0, 5'd16, 0, 1, 16'h5555, 16'h0000, 4'b0000, 4'b0000, 16'h1111, 4'b1111, 4'b0001}); // 12 overflow
      vecs.push_back('{0, 5'd16, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h1111, 4'b1111, 4'b0001}); // 13 unchanged
      vecs.push_back('{0, 5'd31, 1, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, st_8100,  4'b1111, 4'b0001}); // 14 status, clear
      vecs.push_back('{0, 5'd31, 1, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, st_0100,  4'b1111, 4'b0001}); // 15 cleared
      vecs.push_back('{0, 5'd19, 0, 1, 16'h1357, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0001}); // 16 OUT ch3
      vecs.push_back('{0, 5'd19, 0, 1, 16'hA5A5, 16'h0000, 4'b0000, 4'b1000, 16'h1357, 4'b1111, 4'b1001}); // 17 xfer+write
      vecs.push_back('{0, 5'd19, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'hA5A5, 4'b1111, 4'b1001}); // 18
      vecs.push_back('{0, 5'd31, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, st_0900,  4'b1111, 4'b1001}); // 19 no ovf
      vecs.push_back('{0, 5'd0,  0, 0, 16'h0000, 16'h7777, 4'b0001, 4'b0000, 16'h0000, 4'b1111, 4'b1001}); // 20 capture ch0
      vecs.push_back('{0, 5'd17, 0, 1, 16'h2222, 16'h0000, 4'b0000, 4'b0000, 16'h1234, 4'b1110, 4'b1001}); // 21 OUT ch1
      vecs.push_back('{1, 5'd0,  0, 0, 16'h0000, 16'h9999, 4'b0001, 4'b0000, 16'h7777, 4'b0000, 4'b1011}); // 22 reset mid-op
      vecs.push_back('{0, 5'd0,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 23 all clear
      vecs.push_back('{0, 5'd17, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 24
      vecs.push_back('{0, 5'd31, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 25
      vecs.push_back('{0, 5'd1,  0, 0, 16'h0000, 16'h4444, 4'b0010, 4'b0000, 16'h0000, 4'b1111, 4'b0000}); // 26 capture ch1
      vecs.push_back('{0, 5'd1,  1, 1, 16'hFFFF, 16'h0000, 4'b0000, 4'b0000, 16'h4444, 4'b1101, 4'b0000}); // 27 rd+wr
      vecs.push_back('{0, 5'd1,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h4444, 4'b1101, 4'b0000}); // 28 still full
      vecs.push_back('{0, 5'd20, 0, 1, 16'hDEAD, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1101, 4'b0000}); // 29 unmapped wr
      vecs.push_back('{0, 5'd20, 0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1101, 4'b0000}); // 30 ignored
      vecs.push_back('{0, 5'd4,  0, 0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1101, 4'b0000}); // 31 unmapped rd

      // Bring the DUT to a known state before the first checked cycle.
      for (int i = 0; i < N_IN; i++) begin m_ih[i] = '0; m_full[i] = 1'b0; end
      for (int j = 0; j < N_OUT; j++) begin m_oh[j] = '0; m_busy[j] = 1'b0; end
      m_ovf = 1'b0;
      reset = 1'b1; dirport = '0; io_rd = 1'b0; io_wr = 1'b0; wr_data = '0;
      in_data = '0; in_valid = '0; out_ready = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         string tag = $sformatf("row%0d", k);
         step_pre(vecs[k].rst, vecs[k].dp, vecs[k].rd, vecs[k].wr, vecs[k].wd,
                  {N_IN{vecs[k].iw}}, vecs[k].iv, vecs[k].ordy, tag);
         check({tag, " rd_data"},   32'(rd_data),   32'(vecs[k].exp_rd));
         check({tag, " in_ready"},  32'(in_ready),  32'(vecs[k].exp_ir));
         check({tag, " out_valid"}, 32'(out_valid), 32'(vecs[k].exp_ov));
         step_post();
      end

      // ---------------- randomized traffic against the model ----------------
      for (int c = 0; c < 800; c++) begin
         logic [4:0]          dp;
         logic [N_IN*DW-1:0]  idv;
         int                  sel = int'($urandom_range(0, 3));
         case (sel)
            0:       dp = 5'($urandom_range(0, 7));
            1:       dp = 5'($urandom_range(16, 23));
            2:       dp = 5'd31;
            default: dp = 5'($urandom_range(0, 31));
         endcase
         for (int i = 0; i < N_IN; i++) idv[i*DW +: DW] = DW'($urandom);
         step_pre(($urandom_range(0, 63) == 0), dp,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  DW'($urandom), idv, N_IN'($urandom), N_OUT'($urandom),
                  $sformatf("rand%0d", c));
         step_post();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
